// File: rtl/tdc_meas_core.sv
`default_nettype none
// ============================================================================
// Module   : tdc_meas_core
// Purpose  : TDC v2 measurement core. Measures the time from a synchronous
//            start edge to a stop event. The coarse part is a count of whole
//            clk cycles. The fine part is the number of delay-line taps the
//            stop edge has already propagated through. Each result is handed
//            to the consumer over a valid/ready handshake.
// Options  : Defining TDC_AVG_EN turns on burst averaging. One arm then runs
//            2^AVG_LOG2 measurements and presents a single averaged result.
// Ports    : clk          system clock
//            rst          asynchronous, active-high reset
//            arm_i        one-cycle pulse that arms a measurement or a burst
//            start_i      synchronous start level; its rising edge starts timing
//            taps_i       registered delay-line snapshot (ones = taps passed)
//            res_coarse_o coarse result in clk cycles
//            res_fine_o   fine result (popcount of the snapshot)
//            res_valid_o  result valid
//            res_ready_i  consumer accepts the result
//            timeout_o    result is a timeout; qualified by res_valid_o
//            busy_o       high whenever the FSM is not idle
// Timing   : t = coarse*Tclk - fine*Ttap + offset (evaluated in software)
// Revision : 1.0 - initial v2 core
// ============================================================================
module tdc_meas_core #(
  parameter int N_TAPS   = 32,
  parameter int COARSE_W = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm_i,
  input  logic                         start_i,
  input  logic [N_TAPS-1:0]            taps_i,
  output logic [COARSE_W-1:0]          res_coarse_o,
  output logic [$clog2(N_TAPS+1)-1:0]  res_fine_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         timeout_o,
  output logic                         busy_o
);

  localparam int FINE_W = $clog2(N_TAPS+1);
  localparam logic [COARSE_W-1:0] CNT_MAX = {COARSE_W{1'b1}};
  localparam logic [COARSE_W-1:0] CNT_ONE = {{(COARSE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic                start_q;
  logic [COARSE_W-1:0] cnt;

  logic                start_edge;
  logic                hit;
  logic [FINE_W-1:0]   pop;

  // Capture decision for this cycle; the results register loads it at the edge.
  logic                cap_en;
  logic [COARSE_W-1:0] cap_coarse;
  logic [FINE_W-1:0]   cap_fine;
  logic                cap_to;

  assign start_edge = start_i & ~start_q;
  assign hit        = |taps_i;
  assign busy_o     = (state != IDLE);

  // Counting ones rather than locating the first 1->0 transition makes the
  // fine code insensitive to bubbles in the thermometer snapshot.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      pop = pop + {{(FINE_W-1){1'b0}}, taps_i[i]};
    end
  end

  always_comb begin
    cap_en     = 1'b0;
    cap_coarse = '0;
    cap_fine   = '0;
    cap_to     = 1'b0;
    case (state)
      ARMED: begin
        if (start_edge && hit) begin
          cap_en   = 1'b1;
          cap_fine = pop;
        end
      end
      RUN: begin
        if (hit) begin
          cap_en     = 1'b1;
          cap_coarse = cnt;
          cap_fine   = pop;
        end else if (cnt == CNT_MAX) begin
          cap_en     = 1'b1;
          cap_coarse = CNT_MAX;
          cap_to     = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef TDC_AVG_EN
  logic [AVG_LOG2-1:0]          burst_cnt;
  logic [COARSE_W+AVG_LOG2-1:0] acc_coarse;
  logic [FINE_W+AVG_LOG2-1:0]   acc_fine;
  logic [COARSE_W+AVG_LOG2-1:0] sum_coarse;
  logic [FINE_W+AVG_LOG2-1:0]   sum_fine;
  logic                         burst_last;

  // Sums include the sample being captured this cycle, so the final average
  // is available without an extra accumulation cycle.
  assign sum_coarse = acc_coarse + {{AVG_LOG2{1'b0}}, cap_coarse};
  assign sum_fine   = acc_fine   + {{AVG_LOG2{1'b0}}, cap_fine};
  assign burst_last = (burst_cnt == {AVG_LOG2{1'b1}});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      cnt          <= '0;
      res_coarse_o <= '0;
      res_fine_o   <= '0;
      res_valid_o  <= 1'b0;
      timeout_o    <= 1'b0;
`ifdef TDC_AVG_EN
      burst_cnt    <= '0;
      acc_coarse   <= '0;
      acc_fine     <= '0;
`endif
    end else begin
      start_q <= start_i;

      case (state)
        IDLE: begin
          if (arm_i) begin
            state <= ARMED;
`ifdef TDC_AVG_EN
            burst_cnt  <= '0;
            acc_coarse <= '0;
            acc_fine   <= '0;
`endif
          end
        end
        ARMED: begin
          // A start edge with a same-cycle hit is captured below instead.
          if (start_edge && !hit) begin
            cnt   <= CNT_ONE;
            state <= RUN;
          end
        end
        RUN: begin
          // Saturates at CNT_MAX; that value triggers the timeout capture.
          if (!hit && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          if (res_valid_o && res_ready_i) begin
            res_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (cap_en) begin
`ifdef TDC_AVG_EN
        if (cap_to) begin
          // A timeout aborts the whole burst; partial sums are discarded.
          res_coarse_o <= CNT_MAX;
          res_fine_o   <= '0;
          timeout_o    <= 1'b1;
          res_valid_o  <= 1'b1;
          acc_coarse   <= '0;
          acc_fine     <= '0;
          burst_cnt    <= '0;
          state        <= DONE;
        end else if (burst_last) begin
          res_coarse_o <= sum_coarse[COARSE_W+AVG_LOG2-1:AVG_LOG2];
          res_fine_o   <= sum_fine[FINE_W+AVG_LOG2-1:AVG_LOG2];
          timeout_o    <= 1'b0;
          res_valid_o  <= 1'b1;
          acc_coarse   <= '0;
          acc_fine     <= '0;
          burst_cnt    <= '0;
          state        <= DONE;
        end else begin
          // Silent return to ARMED for the next measurement of the burst.
          acc_coarse <= sum_coarse;
          acc_fine   <= sum_fine;
          burst_cnt  <= burst_cnt + {{(AVG_LOG2-1){1'b0}}, 1'b1};
          state      <= ARMED;
        end
`else
        res_coarse_o <= cap_coarse;
        res_fine_o   <= cap_fine;
        timeout_o    <= cap_to;
        res_valid_o  <= 1'b1;
        state        <= DONE;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdc_meas_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_meas_core
// Purpose  : Directed self-checking bench for tdc_meas_core (default params).
// Revision : 1.0 - initial
// ============================================================================
module tb_tdc_meas_core;

  localparam int N_TAPS   = 32;
  localparam int COARSE_W = 8;
  localparam int FINE_W   = 6;
  localparam int AVG_LOG2 = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                arm_i;
  logic                start_i;
  logic [N_TAPS-1:0]   taps_i;
  logic [COARSE_W-1:0] res_coarse_o;
  logic [FINE_W-1:0]   res_fine_o;
  logic                res_valid_o;
  logic                res_ready_i;
  logic                timeout_o;
  logic                busy_o;

  int passed = 0;
  int total  = 0;

  tdc_meas_core #(
    .N_TAPS  (N_TAPS),
    .COARSE_W(COARSE_W),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm_i),
    .start_i     (start_i),
    .taps_i      (taps_i),
    .res_coarse_o(res_coarse_o),
    .res_fine_o  (res_fine_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // One clock: inputs take effect at the posedge, outputs are read at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  // Ensures start is low for a cycle, then raises it. A coarse value of 0
  // puts the hit on the start edge; otherwise coarse-1 empty RUN cycles are
  // followed by the hit cycle. Returns at the negedge after the capture edge.
  task automatic measure(input int coarse, input logic [N_TAPS-1:0] hit_taps);
    start_i = 1'b0;
    taps_i  = '0;
    step();
    start_i = 1'b1;
    if (coarse == 0) taps_i = hit_taps;
    step();
    if (coarse > 0) begin
      for (int k = 1; k < coarse; k++) step();
      taps_i = hit_taps;
      step();
    end
    taps_i  = '0;
    start_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int c, input int f, input logic to);
    check({tag, "_valid"},   res_valid_o,  1'b1);
    check({tag, "_coarse"},  res_coarse_o, c);
    check({tag, "_fine"},    res_fine_o,   f);
    check({tag, "_timeout"}, timeout_o,    to);
  endtask

  initial begin
    rst         = 1'b1;
    arm_i       = 1'b1;
    start_i     = 1'b1;
    taps_i      = 32'hDEAD_BEEF;
    res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",   res_valid_o,  1'b0);
    check("rst_coarse",  res_coarse_o, '0);
    check("rst_fine",    res_fine_o,   '0);
    check("rst_timeout", timeout_o,    1'b0);
    check("rst_busy",    busy_o,       1'b0);
    arm_i   = 1'b0;
    start_i = 1'b0;
    taps_i  = '0;
    rst     = 1'b0;
    step();
    check("idle_busy", busy_o, 1'b0);

`ifndef TDC_AVG_EN
    // Basic: 4 empty RUN cycles then 8 taps -> coarse 5, fine 8.
    arm();
    check("armed_busy", busy_o, 1'b1);
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    check("basic_pre_valid", res_valid_o, 1'b0);
    taps_i = 32'h0000_00FF;
    step();
    taps_i  = '0;
    start_i = 1'b0;
    check_result("basic", 5, 8, 1'b0);
    step();
    check("basic_hs_valid", res_valid_o, 1'b0);
    check("basic_hs_busy",  busy_o,      1'b0);
    check("basic_keep_coarse", res_coarse_o, 5);

    // Hit on the start edge with backpressure.
    res_ready_i = 1'b0;
    arm();
    measure(0, 32'hFFFF_FFFF);
    check_result("edge", 0, 32, 1'b0);
    for (int k = 0; k < 10; k++) begin
      arm_i = k[0];
      step();
      check("bp_valid",  res_valid_o,  1'b1);
      check("bp_coarse", res_coarse_o, 0);
      check("bp_fine",   res_fine_o,   32);
      check("bp_busy",   busy_o,       1'b1);
    end
    // arm_i during the handshake cycle must be ignored.
    arm_i       = 1'b1;
    res_ready_i = 1'b1;
    step();
    arm_i = 1'b0;
    check("bp_hs_valid", res_valid_o, 1'b0);
    check("bp_hs_busy",  busy_o,      1'b0);
    step();
    check("bp_arm_ignored", busy_o, 1'b0);

    // Bubbled snapshot: 0x0F0F has 8 ones.
    arm();
    check("rearm_busy", busy_o, 1'b1);
    measure(2, 32'h0000_0F0F);
    check_result("bubble", 2, 8, 1'b0);
    step();

    // Timeout after 255 RUN cycles.
    arm();
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    step();
    for (int k = 1; k < 255; k++) step();
    check("to_pre_valid", res_valid_o, 1'b0);
    step();
    start_i = 1'b0;
    check_result("timeout", 255, 0, 1'b1);
    step();
    check("to_hs_timeout", timeout_o, 1'b0);
    check("to_hs_busy",    busy_o,    1'b0);

    // Reset mid-RUN clears everything at once.
    arm();
    start_i = 1'b1;
    step();
    step();
    step();
    check("mid_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   busy_o,       1'b0);
    check("mid_rst_coarse", res_coarse_o, '0);
    check("mid_rst_valid",  res_valid_o,  1'b0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    step();
    check("post_rst_valid", res_valid_o, 1'b0);
    arm();
    measure(1, 32'h0000_0003);
    check_result("post_rst", 1, 2, 1'b0);
    step();
`else
    // Averaged burst: coarse 3,4,4,5 / fine 10,12,14,16 -> 4 / 13.
    arm();
    measure(3, 32'h0000_03FF);
    check("avg1_valid", res_valid_o, 1'b0);
    check("avg1_busy",  busy_o,      1'b1);
    measure(4, 32'h0000_0FFF);
    measure(4, 32'h0000_3FFF);
    check("avg3_valid", res_valid_o, 1'b0);
    measure(5, 32'h0000_FFFF);
    check_result("avg", 4, 13, 1'b0);
    step();
    check("avg_hs_busy", busy_o, 1'b0);

    // Timeout in the third measurement aborts the burst.
    arm();
    measure(2, 32'h0000_00FF);
    measure(2, 32'h0000_00FF);
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    for (int k = 0; k < 255; k++) step();
    check("avg_to_pre_valid", res_valid_o, 1'b0);
    step();
    start_i = 1'b0;
    check_result("avg_to", 255, 0, 1'b1);
    step();

    // A fresh burst starts from cleared accumulators.
    arm();
    for (int m = 0; m < 4; m++) measure(2, 32'h0000_000F);
    check_result("avg_clean", 2, 4, 1'b0);
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
